// File: rtl/brew_station_arbiter.sv
// brew_station_arbiter: round-robin owner of one shared brew station.
// Ports: clk, rst (async, active-low); req[NREQ] level requests;
//   cup_ok cup sensor; grant/ack/nak[NREQ] one-hot per requester;
//   cup_drop, pour_valve actuators; busy when not idle.
// All outputs are registered.
module brew_station_arbiter #(
   parameter int NREQ       = 4,
   parameter int CNTW       = 8,
   parameter int CUP_CYC    = 8,
   parameter int CUP_TMO    = 16,
   parameter int POUR_CYC   = 32,
   parameter int SETTLE_CYC = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            cup_ok,
   output logic [NREQ-1:0] grant,
   output logic [NREQ-1:0] ack,
   output logic [NREQ-1:0] nak,
   output logic            cup_drop,
   output logic            pour_valve,
   output logic            busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [CNTW-1:0] CUP_LD    = CNTW'(CUP_CYC - 1);
   localparam logic [CNTW-1:0] TMO_LD    = CNTW'(CUP_TMO - 1);
   localparam logic [CNTW-1:0] POUR_LD   = CNTW'(POUR_CYC - 1);
   localparam logic [CNTW-1:0] SETTLE_LD = CNTW'(SETTLE_CYC - 1);
   localparam logic [NREQ-1:0] ONE       = NREQ'(1);

   typedef enum logic [2:0] {
      IDLE,
      CUP,
      WAIT_CUP,
      POUR,
      SETTLE,
      DONE,
      ABORT
   } state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [NREQ-1:0] nak_q, nak_d;
   logic            cup_drop_q, cup_drop_d;
   logic            pour_valve_q, pour_valve_d;
   logic            busy_q, busy_d;

   logic [IW-1:0]   pick_idx;
   logic            pick_hit;
   logic [IW-1:0]   scan;
   logic [IW-1:0]   nxt_ptr;
   logic            cnt_zero;

   // Walk upward from the pointer, wrapping at NREQ-1; first set bit wins.
   always_comb begin
      pick_idx = '0;
      pick_hit = 1'b0;
      scan     = ptr_q;
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_hit && req[scan]) begin
            pick_hit = 1'b1;
            pick_idx = scan;
         end
         scan = (scan == IW'(NREQ - 1)) ? '0 : scan + IW'(1);
      end
   end

   assign nxt_ptr  = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_hit) begin
               state_d = CUP;
               idx_d   = pick_idx;
               cnt_d   = CUP_LD;
            end
         end
         CUP: begin
            if (cnt_zero) begin
               state_d = WAIT_CUP;
               cnt_d   = TMO_LD;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         WAIT_CUP: begin
            if (cup_ok) begin
               state_d = POUR;
               cnt_d   = POUR_LD;
            end else if (cnt_zero) begin
               state_d = ABORT;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         POUR: begin
            // A vanished cup wins over a finishing pour count.
            if (!cup_ok) begin
               state_d = ABORT;
               cnt_d   = '0;
            end else if (cnt_zero) begin
               state_d = SETTLE;
               cnt_d   = SETTLE_LD;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         SETTLE: begin
            if (cnt_zero) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            ptr_d   = nxt_ptr;
         end
         ABORT: begin
            state_d = IDLE;
            ptr_d   = nxt_ptr;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they land in flops.
   always_comb begin
      grant_d      = '0;
      ack_d        = '0;
      nak_d        = '0;
      cup_drop_d   = 1'b0;
      pour_valve_d = 1'b0;
      busy_d       = (state_d != IDLE);
      case (state_d)
         CUP: begin
            grant_d    = ONE << idx_d;
            cup_drop_d = 1'b1;
         end
         WAIT_CUP: grant_d = ONE << idx_d;
         POUR: begin
            grant_d      = ONE << idx_d;
            pour_valve_d = 1'b1;
         end
         SETTLE: grant_d = ONE << idx_d;
         DONE: begin
            grant_d = ONE << idx_d;
            ack_d   = ONE << idx_d;
         end
         ABORT: begin
            grant_d = ONE << idx_d;
            nak_d   = ONE << idx_d;
         end
         default: begin
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         ptr_q        <= '0;
         grant_q      <= '0;
         ack_q        <= '0;
         nak_q        <= '0;
         cup_drop_q   <= 1'b0;
         pour_valve_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         ptr_q        <= ptr_d;
         grant_q      <= grant_d;
         ack_q        <= ack_d;
         nak_q        <= nak_d;
         cup_drop_q   <= cup_drop_d;
         pour_valve_q <= pour_valve_d;
         busy_q       <= busy_d;
      end
   end

   assign grant      = grant_q;
   assign ack        = ack_q;
   assign nak        = nak_q;
   assign cup_drop   = cup_drop_q;
   assign pour_valve = pour_valve_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_brew_station_arbiter.sv
// tb_brew_station_arbiter: scenario tasks plus randomized services,
// checked cycle by cycle against a timeline model of one service.
module tb_brew_station_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       cup_ok;
   logic [3:0] grant;
   logic [3:0] ack;
   logic [3:0] nak;
   logic       cup_drop;
   logic       pour_valve;
   logic       busy;

   int tests;
   int fails;
   int mptr;

   brew_station_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .cup_ok     (cup_ok),
      .grant      (grant),
      .ack        (ack),
      .nak        (nak),
      .cup_drop   (cup_drop),
      .pour_valve (pour_valve),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [3:0] r, input int p);
      for (int i = 0; i < 4; i++) begin
         if (r[(p + i) % 4]) return (p + i) % 4;
      end
      return -1;
   endfunction

   // Starts at a negedge in an IDLE cycle. d: wait cycle at which the
   // cup appears (>=16 means never). k: pour cycle with cup_ok low
   // (-1 means never). late: bits raised at pour start. drop: granted
   // requester lets go of req early.
   task automatic do_service(input logic [3:0] add, input int d,
                             input int k, input logic [3:0] late,
                             input bit drop);
      int idx, p, tlast;
      logic e_cd, e_pv, e_g, e_ak, e_nk;
      logic [3:0] eg, ea, en, oh;
      req = req | add;
      idx = pick(req, mptr);
      if (idx < 0) begin
         fails++;
         tests++;
         $display("FAIL model no request got %b want nonzero", req);
         return;
      end
      oh = 4'b0001 << idx;
      p = 9 + d;
      if (d >= 16) tlast = 24;
      else if (k < 0) tlast = p + 36;
      else tlast = p + k + 1;
      for (int t = 0; t <= tlast; t++) begin
         @(negedge clk);
         e_cd = (t < 8);
         e_g  = 1'b1;
         e_ak = 1'b0;
         e_nk = 1'b0;
         e_pv = 1'b0;
         if (d >= 16) begin
            e_nk = (t == 24);
         end else if (k < 0) begin
            e_pv = (t >= p) && (t < p + 32);
            e_ak = (t == p + 36);
         end else begin
            e_pv = (t >= p) && (t <= p + k);
            e_nk = (t == p + k + 1);
         end
         eg = e_g ? oh : 4'b0;
         ea = e_ak ? oh : 4'b0;
         en = e_nk ? oh : 4'b0;
         tests++;
         if (grant !== eg) begin
            fails++;
            $display("FAIL grant t=%0d got %b want %b", t, grant, eg);
         end
         tests++;
         if (ack !== ea) begin
            fails++;
            $display("FAIL ack t=%0d got %b want %b", t, ack, ea);
         end
         tests++;
         if (nak !== en) begin
            fails++;
            $display("FAIL nak t=%0d got %b want %b", t, nak, en);
         end
         tests++;
         if (cup_drop !== e_cd) begin
            fails++;
            $display("FAIL cup_drop t=%0d got %b want %b", t, cup_drop, e_cd);
         end
         tests++;
         if (pour_valve !== e_pv) begin
            fails++;
            $display("FAIL pour_valve t=%0d got %b want %b",
                     t, pour_valve, e_pv);
         end
         tests++;
         if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy t=%0d got %b want 1", t, busy);
         end
         if (t < 8) cup_ok = 1'($urandom);
         else if (t < p && (d >= 16 || t < p)) cup_ok = (t - 8 >= d);
         else if (k >= 0 && t - p >= k) cup_ok = 1'b0;
         else if (t < p + 32) cup_ok = 1'b1;
         else cup_ok = 1'($urandom);
         if (t == p && d < 16) req = req | late;
         if (drop && t == 3) req[idx] = 1'b0;
         if (t == tlast) req[idx] = 1'b0;
      end
      @(negedge clk);
      tests++;
      if ({grant, ack, nak, cup_drop, pour_valve, busy} !== 15'b0) begin
         fails++;
         $display("FAIL idle_gap got g=%b a=%b n=%b cd=%b pv=%b b=%b want 0",
                  grant, ack, nak, cup_drop, pour_valve, busy);
      end
      mptr = (idx + 1) % 4;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      req = 4'b1111;
      cup_ok = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({grant, ack, nak, cup_drop, pour_valve, busy} !== 15'b0) begin
         fails++;
         $display("FAIL reset_outputs got g=%b a=%b n=%b cd=%b pv=%b b=%b want 0",
                  grant, ack, nak, cup_drop, pour_valve, busy);
      end
      req = 4'b0;
      rst = 1'b1;
      mptr = 0;
   endtask

   task automatic test_idle;
      req = 4'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (busy !== 1'b0 || grant !== 4'b0) begin
            fails++;
            $display("FAIL idle_no_req got busy=%b grant=%b want 0 0",
                     busy, grant);
         end
      end
   endtask

   task automatic test_single;
      req = 4'b0;
      do_service(4'b0001, 0, -1, 4'b0, 1'b0);
   endtask

   task automatic test_fairness;
      for (int i = 0; i < 5; i++) do_service(4'b1111, 0, -1, 4'b0, 1'b0);
   endtask

   task automatic test_cup_timeout;
      req = 4'b0;
      do_service(4'b0100, 20, -1, 4'b0, 1'b0);
      do_service(4'b0101, 0, -1, 4'b0, 1'b0);
   endtask

   task automatic test_cup_removed;
      req = 4'b0;
      do_service(4'b0001, 0, 10, 4'b0, 1'b0);
   endtask

   task automatic test_late_arrival;
      req = 4'b0;
      do_service(4'b0001, 1, -1, 4'b0100, 1'b0);
      do_service(4'b0000, 0, -1, 4'b0, 1'b0);
   endtask

   task automatic test_drop_mid;
      req = 4'b0;
      do_service(4'b0010, 2, -1, 4'b0, 1'b1);
   endtask

   task automatic test_reset_mid_pour;
      req = 4'b0;
      do_service(4'b0010, 0, -1, 4'b0, 1'b0);
      req = 4'b0100;
      cup_ok = 1'b1;
      repeat (15) @(negedge clk);
      tests++;
      if (pour_valve !== 1'b1 || grant !== 4'b0100) begin
         fails++;
         $display("FAIL pre_reset_pour got pv=%b grant=%b want 1 0100",
                  pour_valve, grant);
      end
      #2 rst = 1'b0;
      #1;
      tests++;
      if ({grant, busy, pour_valve, cup_drop} !== 7'b0) begin
         fails++;
         $display("FAIL async_reset got g=%b b=%b pv=%b cd=%b want 0",
                  grant, busy, pour_valve, cup_drop);
      end
      req = 4'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({ack, nak} !== 8'b0) begin
         fails++;
         $display("FAIL reset_no_pulse got ack=%b nak=%b want 0", ack, nak);
      end
      rst = 1'b1;
      mptr = 0;
      do_service(4'b1001, 0, -1, 4'b0, 1'b0);
      do_service(4'b0000, 0, -1, 4'b0, 1'b0);
   endtask

   task automatic test_random;
      logic [3:0] add;
      int d, k;
      for (int n = 0; n < 20; n++) begin
         add = 4'($urandom_range(0, 15));
         if ((req | add) == 4'b0) add = 4'b0001;
         d = int'($urandom_range(0, 19));
         k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
         do_service(add, d, k, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      mptr = 0;
      rst = 1'b0;
      req = 4'b0;
      cup_ok = 1'b0;
      test_reset;
      test_idle;
      test_single;
      test_fairness;
      test_cup_timeout;
      test_cup_removed;
      test_late_arrival;
      test_drop_mid;
      test_reset_mid_pour;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
